// File: rtl/channel_frame_packer.sv
// channel_frame_packer: gathers serial per-channel samples into a packed parallel frame.
// Latency: frame_valid rises on the cycle after the edge that accepts the last channel.
// Backpressure: s_ready is registered-state only; it drops while a completed frame waits behind a held one.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   s_valid/s_ready/s_data/s_first sample input stream; s_first tags channel 0
//   frame_out/frame_valid/frame_ready  packed frame output (index i = channel i)
//   err_resync                     one-cycle pulse when a partial frame is dropped
//   err_count                      saturating resync count
//
// Optional feature: define MARTIN_RESYNC_COUNT_EN to build the 8-bit saturating
// resync counter behind err_count; otherwise err_count is constant zero.

module channel_frame_packer #(
  parameter int CHANNELS         = 8,
  parameter int BITS_PER_CHANNEL = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [BITS_PER_CHANNEL-1:0]                s_data,
  input  logic                                       s_first,
  output logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0]  frame_out,
  output logic                                       frame_valid,
  input  logic                                       frame_ready,
  output logic                                       err_resync,
  output logic [7:0]                                 err_count
);

  localparam int IW = $clog2(CHANNELS);
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] frame_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  frame_t          fill_q, fill_d;
  frame_t          out_q, out_d;
  logic            vld_q, vld_d;
  logic            resync_q, resync_d;

  logic            accept;
  logic            slot_free;

  // FULL is the only stall state, so s_ready never sees frame_ready.
  assign s_ready   = (state_q == FILL) && !rst;
  assign accept    = s_valid && s_ready;
  // The output slot can take a new frame if it is empty or being drained now.
  assign slot_free = !vld_q || frame_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      idx_q    <= '0;
      fill_q   <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fill_q   <= fill_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      resync_q <= resync_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fill_d   = fill_q;
    out_d    = out_q;
    // A drain with nothing new to load empties the slot.
    vld_d    = vld_q && !frame_ready;
    resync_d = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (s_first && (idx_q != '0)) begin
            // Resync wins over completion, even at the last slot. Stale slots
            // above 0 are harmless: a frame is only released after a full refill.
            fill_d[0] = s_data;
            idx_d     = IW'(1);
            resync_d  = 1'b1;
          end else if (idx_q == LAST) begin
            if (slot_free) begin
              // Bypass the fill buffer so back-to-back frames have no bubble.
              out_d       = fill_q;
              out_d[LAST] = s_data;
              vld_d       = 1'b1;
              idx_d       = '0;
            end else begin
              fill_d[LAST] = s_data;
              state_d      = FULL;
            end
          end else begin
            fill_d[idx_q] = s_data;
            idx_d         = idx_q + IW'(1);
          end
        end
      end

      FULL: begin
        if (slot_free) begin
          out_d   = fill_q;
          vld_d   = 1'b1;
          idx_d   = '0;
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign frame_out   = out_q;
  assign frame_valid = vld_q;
  assign err_resync  = resync_q;

`ifdef MARTIN_RESYNC_COUNT_EN
  logic [7:0] cnt_q;

  // Counts in step with the err_resync pulse; sticks at 255 until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (resync_d && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign err_count = cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_channel_frame_packer.sv
module tb_channel_frame_packer;

  localparam int CH = 8;
  localparam int B  = 8;
  localparam int FW = CH * B;

  typedef logic [CH-1:0][B-1:0] frame_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [B-1:0]   s_data = '0;
  logic           s_first = 1'b0;
  frame_t         frame_out;
  logic           frame_valid;
  logic           frame_ready = 1'b0;
  logic           err_resync;
  logic [7:0]     err_count;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

  // Reference model: samples of the frame being gathered, and complete frames
  // in order of completion (front = the frame the consumer should see now).
  logic [B-1:0] partial[$];
  frame_t       frames[$];
  logic         exp_err = 1'b0;
  int           exp_cnt = 0;
  logic         just_reset = 1'b0;

  channel_frame_packer #(.CHANNELS(CH), .BITS_PER_CHANNEL(B)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
    .frame_out(frame_out), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .err_resync(err_resync), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       frame_ready = 1'b0;
        1:       frame_ready = 1'b1;
        default: frame_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard: compares DUT against the model mid-cycle, then
  // advances the model by whatever handshakes will occur at the next edge.
  initial begin
    frame_t f;
    logic   drain;
    logic   acc;
    logic   err_n;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("s_ready_in_reset", FW'(s_ready), FW'(0));
        partial.delete();
        frames.delete();
        exp_err    = 1'b0;
        exp_cnt    = 0;
        just_reset = 1'b1;
      end else begin
        if (just_reset) begin
          chk("frame_out_reset", FW'(frame_out), FW'(0));
          just_reset = 1'b0;
        end
        chk("err_resync", FW'(err_resync), FW'(exp_err));
        chk("err_count", FW'(err_count), FW'(exp_cnt));
        chk("frame_valid", FW'(frame_valid), FW'(frames.size() > 0));
        chk("s_ready", FW'(s_ready), FW'(frames.size() < 2));
        if (frame_valid && frames.size() > 0)
          chk("frame_out", FW'(frame_out), FW'(frames[0]));

        drain = frame_valid && frame_ready;
        acc   = s_valid && s_ready;
        err_n = 1'b0;
        if (drain && frames.size() > 0) void'(frames.pop_front());
        if (acc) begin
          if (s_first && partial.size() > 0) begin
            partial.delete();
            partial.push_back(s_data);
            err_n = 1'b1;
`ifdef MARTIN_RESYNC_COUNT_EN
            if (exp_cnt < 255) exp_cnt++;
`endif
          end else begin
            partial.push_back(s_data);
            if (partial.size() == CH) begin
              for (int i = 0; i < CH; i++) f[i] = partial[i];
              frames.push_back(f);
              partial.delete();
            end
          end
        end
        exp_err = err_n;
      end
    end
  end

  task automatic send(input logic [B-1:0] d, input logic first);
    logic ok;
    int   n;
    s_valid = 1'b1;
    s_data  = d;
    s_first = first;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [B-1:0] base);
    for (int i = 0; i < CH; i++) send(base + B'(i), i == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    rdy_mode = 1;
    idle(2);

    // Basic frame 0x10..0x17.
    send_frame(8'h10);
    idle(3);

    // Three back-to-back random frames.
    for (int k = 0; k < 3 * CH; k++) send(B'($urandom), (k % CH) == 0);
    idle(3);

    // Held frame A, then B fills behind it and stalls in FULL.
    rdy_mode = 0;
    send_frame(8'h30);
    send_frame(8'h20);
    idle(4);
    rdy_mode = 1;
    idle(4);

    // Resync after 5 samples.
    for (int i = 0; i < 5; i++) send(8'h50 + B'(i), i == 0);
    send(8'hAA, 1'b1);
    for (int i = 1; i < CH; i++) send(B'(i), 1'b0);
    idle(3);

    // Resync at the last slot, and s_first=0 at slot 0.
    for (int i = 0; i < CH - 1; i++) send(8'h60 + B'(i), 1'b0);
    send(8'hBB, 1'b1);
    for (int i = 1; i < CH; i++) send(8'h70 + B'(i), 1'b0);
    idle(3);

    // Reset with a frame held and a partial frame in progress.
    rdy_mode = 0;
    send_frame(8'h80);
    for (int i = 0; i < 4; i++) send(8'h90 + B'(i), i == 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rdy_mode = 1;
    idle(1);
    send_frame(8'hC0);
    idle(3);

    // Random traffic with random consumer stalls and random resyncs.
    rdy_mode = 2;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(B'($urandom), $urandom_range(0, 6) == 0);
    end
    rdy_mode = 1;
    idle(4);

    // Force many resyncs to exercise counter saturation.
    for (int k = 0; k < 301; k++) send(B'(k), 1'b1);
    idle(3);
`ifdef MARTIN_RESYNC_COUNT_EN
    chk("err_count_saturated", FW'(err_count), FW'(255));
`else
    chk("err_count_tied_zero", FW'(err_count), FW'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_frame_packer.md
# channel_frame_packer

Producer-side companion to the 8-channel median stage. It accepts a stream of per-channel samples, one per handshake, and assembles them into a full parallel frame. It then presents the frame as a packed channel vector with valid/ready, ready to be consumed unchanged by the median stage. Partial frames are discarded on resynchronisation, and a completed frame waits in a holding state until the consumer accepts it.

## Interface
- `CHANNELS`, default 8: number of channels per frame; must be ≥2.
- `BITS_PER_CHANNEL`, default 8: width of one sample.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `s_valid`  in  1: upstream sample valid.
- `s_ready`  out  1: packer can accept a sample this cycle.
- `s_data`  in  `BITS_PER_CHANNEL`: sample value.
- `s_first`  in  1: marks the sample as channel 0 of a new frame.
- `frame_out`  out  [`CHANNELS`-1:0][`BITS_PER_CHANNEL`-1:0]: assembled frame; index i holds channel i.
- `frame_valid`  out  1: `frame_out` holds a complete frame.
- `frame_ready`  in  1: consumer accepts the frame this cycle.
- `err_resync`  out  1: one-cycle pulse when a partial frame is dropped.
- `err_count`  out  8: saturating count of resync events (see Configuration).

## Operation
- Accept event = `s_valid && s_ready`. Drain event = `frame_valid && frame_ready`.
- Fill index `idx` runs from 0 to `CHANNELS`-1. An accepted sample is written to fill-buffer slot `idx`, and `idx` increments.
- States:
  - FILL: `s_ready`=1.
  - FULL: `s_ready`=0. A complete frame is waiting for the output slot.
- Frame completion: an accept at `idx`=`CHANNELS`-1 with `s_first`=0 completes the frame.
  - If the output slot is free (`!frame_valid`) or draining this cycle, load `frame_out` directly with the buffer plus the incoming sample. Set `frame_valid`=1 and `idx`=0, and stay in FILL.
  - Otherwise, store the sample in the buffer and go to FULL.
- In FULL, when the slot frees (`!frame_valid || frame_ready`), move the buffer into `frame_out`, set `frame_valid`=1 and `idx`=0, and return to FILL.
- Resync: an accepted `s_first`=1 at `idx`≠0 does the following:
  - discards the partial frame;
  - writes the sample to slot 0 and sets `idx`=1;
  - pulses `err_resync` in the next cycle and increments `err_count`.
  - This includes `idx`=`CHANNELS`-1: resync takes priority over completion.
- `s_first`=0 at `idx`=0 is accepted as channel 0 with no error.
- A drain event with no new frame loading clears `frame_valid` on the next edge.
- `frame_out` is held stable whenever `frame_valid`=1 and `frame_ready`=0.
- Unfilled slots are never exposed. A frame is presented only when all `CHANNELS` slots were written since the last `idx`=0.

## Timing
- Reset values:
  - `frame_valid`=0, `frame_out`=0, `err_resync`=0, `err_count`=0.
  - `idx`=0, state FILL.
  - `s_ready`=0 while `rst`=1, and 1 in the first cycle after `rst` deasserts.
- A reset asserted mid-frame or with a held frame discards everything, with no error pulse.
- Latency: `frame_valid` rises in the cycle after the edge that accepted the last channel.
- Throughput: with `frame_ready` held at 1, one sample per cycle is sustained. A frame is presented every `CHANNELS` cycles with no bubbles.
- Back-to-back: a drain event and completion on the same edge load the new frame, and `frame_valid` stays 1.
- Stall behaviour: `s_ready` depends only on registered state, with no combinational path from `frame_ready` to `s_ready`. At most `CHANNELS` samples can be buffered beyond the held frame before stall.
- If the slot frees, FULL exits on the same cycle and `s_ready` returns to 1 in the next cycle.

## Configuration
- `MARTIN_RESYNC_COUNT_EN` defined:
  - `err_count` is an 8-bit counter, incremented on each resync event.
  - It saturates at 255 and is cleared only by `rst`.
- Not defined:
  - `err_count` is tied to 0 and no counter register is synthesised.
  - `err_resync` still operates.

## Test plan
- Reset, then 8 consecutive accepts with data 0x10..0x17 (`s_first` on the first) and `frame_ready`=1 -> `frame_valid`=1 for one cycle, one cycle after the 8th accept, with `frame_out[i]`=0x10+i.
- Continuous stream of 3 frames with `frame_ready`=1 -> three frames presented at an 8-cycle spacing, `s_ready` never drops.
- Hold `frame_ready`=0 after frame A and push frame B (0x20..0x27):
  - expected: B's 8th accept puts the packer in FULL with `s_ready`=0, and `frame_out` stays on A;
  - then raise `frame_ready` -> A is drained, B is presented next cycle, and `s_ready`=1 in the following cycle.
- 5 samples, then a sample 0xAA with `s_first`=1, then 7 more samples 0x01..0x07:
  - expected: `err_resync` pulses once, and the frame presented is 0xAA,0x01..0x07;
  - with the macro defined, `err_count`=1.
- Assert `rst` for 1 cycle after 4 samples while a frame is held -> `frame_valid`=0 and `err_count`=0. The next 8 accepts produce a clean frame.
- With `MARTIN_RESYNC_COUNT_EN`, force 300 resyncs -> `err_count`=255. Without the macro -> `err_count`=0 throughout.
